// File: rtl/rptr_fwft_handler_if.sv
// rptr_fwft_handler_if: write-pointer input, memory read port and output stream of rptr_fwft_handler.
// slave is the handler side; master is the memory/producer/consumer side.
interface rptr_fwft_handler_if #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 8
);
    logic [PTR_WIDTH:0]    g_wptr;
    logic [PTR_WIDTH:0]    b_rptr;
    logic [PTR_WIDTH:0]    g_rptr;
    logic [PTR_WIDTH:0]    rd_level;
    logic [PTR_WIDTH-1:0]  raddr;
    logic [DATA_WIDTH-1:0] rd_data_mem;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic                  mem_ren;
    logic                  empty;
    logic                  aempty;
    logic                  m_valid;
    modport slave (
        input  g_wptr, rd_data_mem, m_ready,
        output mem_ren, raddr, b_rptr, g_rptr, empty, aempty, rd_level, m_valid, m_data
    );
    modport master (
        output g_wptr, rd_data_mem, m_ready,
        input  mem_ren, raddr, b_rptr, g_rptr, empty, aempty, rd_level, m_valid, m_data
    );
endinterface

// File: rtl/rptr_fwft_handler.sv
// rptr_fwft_handler: async-FIFO read pointer handler with a 2-entry first-word-fall-through output buffer.
// Define RPTR_SYNC3_EN for a 3-flop write-pointer synchronizer (default is 2 flops).
module rptr_fwft_handler #(
    parameter int PTR_WIDTH     = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic               wclk,
    input  logic               wrst,
    rptr_fwft_handler_if.slave bus
);
    localparam int PW = PTR_WIDTH;
    localparam logic [PW:0] AE = (PW+1)'(AEMPTY_THRESH);
    logic [PW:0]           r_wptr_s1, r_wptr_s2, w_g_wptr_sync, w_b_wptr_sync;
    logic [PW:0]           r_b_rptr, r_g_rptr, r_rd_level;
    logic [PW:0]           w_b_rptr_next, w_g_rptr_next, w_level_next;
    logic [1:0]            r_buf_cnt;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_empty, r_aempty, r_inflight;
    logic                  w_pop, w_mem_ren, w_m_valid, w_wr_idx;

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_wptr_s1 <= '0;
            r_wptr_s2 <= '0;
        end else begin
            r_wptr_s1 <= bus.g_wptr;
            r_wptr_s2 <= r_wptr_s1;
        end
    end

`ifdef RPTR_SYNC3_EN
    logic [PW:0] r_wptr_s3;
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) r_wptr_s3 <= '0;
        else r_wptr_s3 <= r_wptr_s2;
    end
    assign w_g_wptr_sync = r_wptr_s3;
`else
    assign w_g_wptr_sync = r_wptr_s2;
`endif

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i <= PW; i++) begin : g_g2b
        assign w_b_wptr_sync[i] = ^w_g_wptr_sync[PW:i];
    end

    assign w_m_valid     = r_buf_cnt != 2'd0;
    assign w_pop         = w_m_valid && bus.m_ready;
    assign w_mem_ren     = !r_empty && (({1'b0, r_buf_cnt} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
    assign w_b_rptr_next = r_b_rptr + {{PW{1'b0}}, w_mem_ren};
    assign w_g_rptr_next = (w_b_rptr_next >> 1) ^ w_b_rptr_next;
    assign w_level_next  = w_b_wptr_sync - w_b_rptr_next;
    // Slot for the arriving word is the count left after this cycle's pop.
    assign w_wr_idx      = r_buf_cnt[0] ^ w_pop;

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            r_b_rptr   <= '0;
            r_g_rptr   <= '0;
            r_empty    <= 1'b1;
            r_aempty   <= 1'b1;
            r_rd_level <= '0;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_b_rptr   <= w_b_rptr_next;
            r_g_rptr   <= w_g_rptr_next;
            r_empty    <= w_g_rptr_next == w_g_wptr_sync;
            r_aempty   <= w_level_next <= AE;
            r_rd_level <= w_level_next;
            r_inflight <= w_mem_ren;
            r_buf_cnt  <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_pop) r_buf[0] <= r_buf[1];
            if (r_inflight) r_buf[w_wr_idx] <= bus.rd_data_mem;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) assert (!(r_inflight && r_buf_cnt == 2'd2 && !w_pop)) else $error("rptr_fwft_handler: output buffer overflow");
    end

    assign bus.mem_ren  = w_mem_ren;
    assign bus.raddr    = r_b_rptr[PW-1:0];
    assign bus.b_rptr   = r_b_rptr;
    assign bus.g_rptr   = r_g_rptr;
    assign bus.empty    = r_empty;
    assign bus.aempty   = r_aempty;
    assign bus.rd_level = r_rd_level;
    assign bus.m_valid  = w_m_valid;
    assign bus.m_data   = r_buf[0];
endmodule

// File: tb/tb_rptr_fwft_handler.sv
// tb_rptr_fwft_handler: directed and randomized bench for rptr_fwft_handler.
// Words written by the bench producer are queued and must emerge in order on the stream.
module tb_rptr_fwft_handler;
    localparam int PW = 3;
    localparam int DW = 8;
`ifdef RPTR_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    logic          wclk = 1'b0;
    logic          wrst = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] mem [8];
    logic [DW-1:0] q [$];
    logic [PW:0]   wp = '0;
    logic          wrapped = 1'b0;

    rptr_fwft_handler_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) bus ();
    rptr_fwft_handler #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AEMPTY_THRESH(1)) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus (bus)
    );

    always #5 wclk = ~wclk;
    always @(posedge wclk) if (bus.mem_ren) bus.rd_data_mem <= mem[bus.raddr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW:0] gray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any transfer at the negedge, then check Gray step and hold rule after the edge.
    task automatic tick();
        logic [PW:0]   pg, pb;
        logic [DW-1:0] e, pd;
        logic          ph;
        #4;
        if (bus.m_valid && bus.m_ready) begin
            if (q.size() != 0) e = q.pop_front();
            else e = 'x;
            chk("m_data", 32'(bus.m_data), 32'(e));
        end
        ph = bus.m_valid && !bus.m_ready;
        pd = bus.m_data;
        pg = bus.g_rptr;
        pb = bus.b_rptr;
        @(posedge wclk);
        #1;
        chk("g_step", 32'($countones(pg ^ bus.g_rptr) <= 1), 1);
        if (ph) chk("m_hold", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, pd});
        if (pb == '1 && bus.b_rptr == '0) wrapped = 1'b1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        mem[wp[PW-1:0]] = d;
        q.push_back(d);
        wp = wp + 1'b1;
        bus.g_wptr = gray(wp);
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || bus.m_valid); i++) tick();
        chk("drain", q.size(), 0);
        chk("b_rptr_end", 32'(bus.b_rptr), 32'(wp));
        chk("g_rptr_end", 32'(bus.g_rptr), 32'(gray(wp)));
        chk("empty_end", 32'(bus.empty), 1);
    endtask

    task automatic pop_one();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [DW-1:0] first;
        logic [PW:0]   diff;
        bus.g_wptr = '0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.g_wptr = (PW+1)'($urandom);
            tick();
        end
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_aempty", 32'(bus.aempty), 1);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_mem_ren", 32'(bus.mem_ren), 0);
        chk("rst_b_rptr", 32'(bus.b_rptr), 0);
        chk("rst_g_rptr", 32'(bus.g_rptr), 0);
        chk("rst_rd_level", 32'(bus.rd_level), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        bus.g_wptr = '0;
        wrst = 1'b1;
        repeat (3) tick();

        bus.m_ready = 1'b1;
        wr(8'hA5);
        for (int i = 0; i < SYNC; i++) begin
            tick();
            chk("empty_wait", 32'(bus.empty), 1);
        end
        tick();
        chk("empty_fall", 32'(bus.empty), 0);
        chk("ren_pulse", 32'(bus.mem_ren), 1);
        tick();
        chk("ren_once", 32'(bus.mem_ren), 0);
        chk("b_rptr_1", 32'(bus.b_rptr), 1);
        chk("empty_last", 32'(bus.empty), 1);
        chk("mv_latency", 32'(bus.m_valid), 0);
        tick();
        chk("mv_rise", 32'(bus.m_valid), 1);
        chk("data_a5", 32'(bus.m_data), 32'hA5);
        tick();
        chk("mv_fall", 32'(bus.m_valid), 0);

        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'($urandom));
        first = q[0];
        repeat (SYNC + 6) tick();
        chk("bp_b_rptr", 32'(bus.b_rptr), 3);
        chk("bp_m_valid", 32'(bus.m_valid), 1);
        chk("bp_rd_level", 32'(bus.rd_level), 6);
        chk("bp_aempty", 32'(bus.aempty), 0);
        chk("bp_mem_ren", 32'(bus.mem_ren), 0);
        chk("bp_head", 32'(bus.m_data), 32'(first));
        bus.m_ready = 1'b1;
        repeat (8) tick();
        chk("bp_rate", q.size(), 0);
        chk("bp_mv_end", 32'(bus.m_valid), 0);
        chk("bp_empty", 32'(bus.empty), 1);

        for (int n = 0; n < 20;) begin
            diff = wp - bus.b_rptr;
            if (diff < 8) begin
                wr(8'($urandom));
                n++;
            end
            tick();
        end
        drain();
        chk("wrap_seen", 32'(wrapped), 1);

        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'($urandom));
        repeat (SYNC + 6) tick();
        chk("ae_lvl3", {31'd0, bus.aempty} << 8 | 32'(bus.rd_level), {31'd0, 1'b0} << 8 | 32'd3);
        pop_one();
        chk("ae_lvl2", {31'd0, bus.aempty} << 8 | 32'(bus.rd_level), {31'd0, 1'b0} << 8 | 32'd2);
        pop_one();
        chk("ae_lvl1", {31'd0, bus.aempty} << 8 | 32'(bus.rd_level), {31'd0, 1'b1} << 8 | 32'd1);
        pop_one();
        chk("ae_lvl0", {31'd0, bus.aempty} << 8 | 32'(bus.rd_level), {31'd0, 1'b1} << 8 | 32'd0);
        chk("ae_empty", 32'(bus.empty), 1);
        drain();

        for (int n = 0; n < 40;) begin
            bus.m_ready = 1'($urandom);
            diff = wp - bus.b_rptr;
            if (diff < 8 && $urandom_range(0, 1) == 1) begin
                wr(8'($urandom));
                n++;
            end
            tick();
        end
        drain();

        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        for (int i = 0; i < 20 && !bus.m_valid; i++) tick();
        chk("mr_pre_valid", 32'(bus.m_valid), 1);
        #1 wrst = 1'b0;
        #1;
        chk("mr_m_valid", 32'(bus.m_valid), 0);
        chk("mr_mem_ren", 32'(bus.mem_ren), 0);
        chk("mr_empty", 32'(bus.empty), 1);
        chk("mr_aempty", 32'(bus.aempty), 1);
        chk("mr_b_rptr", 32'(bus.b_rptr), 0);
        chk("mr_g_rptr", 32'(bus.g_rptr), 0);
        chk("mr_rd_level", 32'(bus.rd_level), 0);
        chk("mr_m_data", 32'(bus.m_data), 0);
        q.delete();
        wp = '0;
        bus.g_wptr = '0;
        bus.m_ready = 1'b1;
        #1 wrst = 1'b1;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mr_no_stale", {30'd0, bus.m_valid, bus.mem_ren}, 0);
        end
        wr(8'h3C);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
